// File: rtl/calc_param_if.sv
// Token handshake and result bus between a token source and calc_param.
interface calc_param_if #(parameter int WIDTH = 16);
  logic             validIn;
  logic             readyOut;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             validOut;
  logic             ovf;
  logic             err;

  modport master (output validIn, output dataIn,
                  input readyOut, input dataOut, input validOut, input ovf, input err);
  modport slave  (input validIn, input dataIn,
                  output readyOut, output dataOut, output validOut, output ovf, output err);
endinterface

// File: rtl/calc_param.sv
// Token-serial WIDTH-bit calculator: operand A, opcode, optional operand B,
// with a one-bit-per-cycle shift-add multiplier and optional result chaining.
//
// state  | meaning
// IDLE   | waiting for operand A
// OPC    | waiting for opcode token (A held, or previous result when chaining)
// OPB    | waiting for operand B of a binary op
// MUL    | shift-add multiply in progress, tokens refused
module calc_param #(
  parameter int WIDTH = 16,
  parameter bit CHAIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  calc_param_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_OPC, S_OPB, S_MUL} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SQR = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_DEC = 3'd7;

  state_t             state;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         op;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   data_out;
  logic               valid_out;
  logic               ovf_r;
  logic               err_r;

  logic               accept;
  logic               opc_bad;
  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   rhs;
  logic [WIDTH:0]     alu;
  logic               fin_en;
  logic [WIDTH-1:0]   fin_val;
  logic               fin_ovf;

  assign bus.readyOut = (state != S_MUL);
  assign bus.dataOut  = data_out;
  assign bus.validOut = valid_out;
  assign bus.ovf      = ovf_r;
  assign bus.err      = err_r;

  assign accept   = bus.validIn && bus.readyOut;
  assign opc_bad  = (bus.dataIn > WIDTH'(7));
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  // The opcode/operand being applied this cycle come straight off the bus
  // in OPC/OPB so single-cycle ops complete on the accepting edge.
  always_comb begin
    op_sel = (state == S_OPC) ? bus.dataIn[2:0] : op;
    rhs    = (state == S_OPB) ? bus.dataIn : b;
    alu    = '0;
    case (op_sel)
      OP_ADD:  alu = {1'b0, a} + {1'b0, rhs};
      OP_INC:  alu = {1'b0, a} + (WIDTH+1)'(1);
      OP_SUB:  alu = {1'b0, a} - {1'b0, rhs};
      OP_AND:  alu = {1'b0, a & rhs};
      OP_XOR:  alu = {1'b0, a ^ rhs};
      OP_DEC:  alu = {1'b0, a} - (WIDTH+1)'(1);
      default: alu = '0;
    endcase
  end

  always_comb begin
    fin_en  = 1'b0;
    fin_val = alu[WIDTH-1:0];
    fin_ovf = alu[WIDTH];
    case (state)
      S_OPC:   fin_en = accept && !opc_bad &&
                        (bus.dataIn[2:0] == OP_INC || bus.dataIn[2:0] == OP_DEC);
      S_OPB:   fin_en = accept && (op != OP_MUL);
      S_MUL: begin
        fin_en  = (cnt == '0);
        fin_val = prod_nxt[WIDTH-1:0];
        fin_ovf = |prod_nxt[2*WIDTH-1:WIDTH];
      end
      default: fin_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      mplier    <= '0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
    end else if (clr) begin
      state     <= S_IDLE;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      mplier    <= '0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      ovf_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a        <= bus.dataIn;
            data_out <= bus.dataIn;
            err_r    <= 1'b0;
            state    <= S_OPC;
          end
        end
        S_OPC: begin
          if (accept) begin
            if (opc_bad) begin
              err_r <= 1'b1;
              state <= S_IDLE;
            end else begin
              op <= bus.dataIn[2:0];
              if (bus.dataIn[2:0] == OP_SQR) begin
                mplier <= a;
                mcand  <= {{WIDTH{1'b0}}, a};
                prod   <= '0;
                cnt    <= CW'(WIDTH-1);
                state  <= S_MUL;
              end else begin
                state <= S_OPB;
              end
            end
          end
        end
        S_OPB: begin
          if (accept) begin
            b     <= bus.dataIn;
            err_r <= 1'b0;
            if (op == OP_MUL) begin
              mplier <= bus.dataIn;
              mcand  <= {{WIDTH{1'b0}}, a};
              prod   <= '0;
              cnt    <= CW'(WIDTH-1);
              state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      // Result edge overrides whatever next state the case above chose.
      if (fin_en) begin
        data_out  <= fin_val;
        ovf_r     <= fin_ovf;
        valid_out <= 1'b1;
        if (CHAIN) begin
          a     <= fin_val;
          state <= S_OPC;
        end else begin
          state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_param.sv
// Directed bench for calc_param: vector table on a CHAIN=0 instance plus
// hand sequences for busy window, illegal opcode, chaining, reset and clear.
module tb_calc_param;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  calc_param_if #(.WIDTH(W)) b0 ();
  calc_param_if #(.WIDTH(W)) b1 ();

  calc_param #(.WIDTH(W), .CHAIN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .clr(clr0), .bus(b0.slave));
  calc_param #(.WIDTH(W), .CHAIN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr1), .bus(b1.slave));

  typedef struct {
    int         n;
    logic [W-1:0] t0, t1, t2;
    logic [W-1:0] d;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit sel, input logic [W-1:0] v);
    int n = 0;
    while (!(sel ? b1.readyOut : b0.readyOut) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      total_cnt++;
      $display("FAIL send_ready_timeout: got readyOut 0 expected 1");
    end
    if (sel) begin b1.validIn = 1'b1; b1.dataIn = v; end
    else     begin b0.validIn = 1'b1; b0.dataIn = v; end
    @(negedge clk);
    b0.validIn = 1'b0;
    b1.validIn = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? b1.validOut : b0.validOut) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    b0.validIn = 1'b0; b0.dataIn = '0;
    b1.validIn = 1'b0; b1.dataIn = '0;

    //            n  t0       t1    t2       d        ovf   lat
    vecs[0]  = '{3, 16'd12,   16'd1, 16'd30,  16'd42,    1'b0, 0};
    vecs[1]  = '{2, 16'hFFFF, 16'd3, 16'd0,   16'h0000,  1'b1, 0};
    vecs[2]  = '{3, 16'd5,    16'd4, 16'd7,   16'hFFFE,  1'b1, 0};
    vecs[3]  = '{2, 16'd0,    16'd7, 16'd0,   16'hFFFF,  1'b1, 0};
    vecs[4]  = '{3, 16'h00FF, 16'd6, 16'h0F0F, 16'h0FF0, 1'b0, 0};
    vecs[5]  = '{3, 16'hF0F0, 16'd5, 16'h3C3C, 16'h3030, 1'b0, 0};
    vecs[6]  = '{3, 16'hFFFF, 16'd1, 16'd1,   16'h0000,  1'b1, 0};
    vecs[7]  = '{2, 16'd7,    16'd3, 16'd0,   16'd8,     1'b0, 0};
    vecs[8]  = '{2, 16'h1234, 16'd7, 16'd0,   16'h1233,  1'b0, 0};
    vecs[9]  = '{3, 16'd3,    16'd4, 16'd3,   16'd0,     1'b0, 0};
    vecs[10] = '{3, 16'd300,  16'd0, 16'd300, 16'd24464, 1'b1, W};
    vecs[11] = '{3, 16'd255,  16'd0, 16'd257, 16'd65535, 1'b0, W};
    vecs[12] = '{2, 16'd256,  16'd2, 16'd0,   16'd0,     1'b1, W};
    vecs[13] = '{2, 16'd200,  16'd2, 16'd0,   16'd40000, 1'b0, W};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", b0.readyOut, 1);
    check("rst_data", b0.dataOut, 0);
    check("rst_valid", b0.validOut, 0);
    check("rst_ovf_err", {b0.ovf, b0.err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      send(1'b0, vecs[i].t0);
      send(1'b0, vecs[i].t1);
      if (vecs[i].n == 3) send(1'b0, vecs[i].t2);
      wait_valid(1'b0, lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_data", i), b0.dataOut, vecs[i].d);
      check($sformatf("v%0d_ovf", i), b0.ovf, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), {b0.validOut, b0.readyOut}, 2'b01);
    end

    // MUL with tokens offered during the busy window
    send(1'b0, 16'd300); send(1'b0, 16'd0); send(1'b0, 16'd300);
    check("busy_ready", b0.readyOut, 0);
    b0.validIn = 1'b1; b0.dataIn = 16'd9;
    repeat (5) @(negedge clk);
    b0.validIn = 1'b0;
    wait_valid(1'b0, lat);
    check("busy_lat", lat + 5, W);
    check("busy_data", b0.dataOut, 24464);
    check("busy_ovf", b0.ovf, 1);
    @(negedge clk);
    send(1'b0, 16'd2); send(1'b0, 16'd3);
    check("busy_after_inc", {b0.validOut, b0.dataOut}, {1'b1, 16'd3});
    @(negedge clk);

    // Illegal opcode, then recovery
    send(1'b0, 16'd9); send(1'b0, 16'd9);
    check("bad_err", b0.err, 1);
    check("bad_valid", b0.validOut, 0);
    check("bad_data", b0.dataOut, 9);
    send(1'b0, 16'd4);
    check("bad_clear_err", {b0.err, b0.dataOut}, {1'b0, 16'd4});
    send(1'b0, 16'd3);
    check("bad_next_inc", {b0.validOut, b0.dataOut}, {1'b1, 16'd5});
    @(negedge clk);

    // Chaining: SQR then ADD 1 without re-entering an operand
    send(1'b1, 16'd3); send(1'b1, 16'd2);
    wait_valid(1'b1, lat);
    check("chain_sqr_lat", lat, W);
    check("chain_sqr", {b1.validOut, b1.dataOut}, {1'b1, 16'd9});
    @(negedge clk);
    check("chain_pulse", b1.validOut, 0);
    send(1'b1, 16'd1); send(1'b1, 16'd1);
    check("chain_add", {b1.validOut, b1.dataOut}, {1'b1, 16'd10});
    @(negedge clk);

    // Reset 8 cycles into a MUL
    send(1'b0, 16'd300); send(1'b0, 16'd0); send(1'b0, 16'd300);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmul_outs", {b0.dataOut, b0.validOut, b0.ovf, b0.err}, 0);
    check("rstmul_ready", b0.readyOut, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b0.validOut) pulses++;
    end
    check("rstmul_no_valid", pulses, 0);
    send(1'b0, 16'd2); send(1'b0, 16'd3);
    check("rstmul_after", {b0.validOut, b0.dataOut}, {1'b1, 16'd3});
    @(negedge clk);

    // Clear while waiting for operand B
    send(1'b0, 16'd5); send(1'b0, 16'd1);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("clr_outs", {b0.dataOut, b0.ovf, b0.err, b0.readyOut}, {16'd0, 3'b001});
    send(1'b0, 16'd7); send(1'b0, 16'd3);
    check("clr_after", {b0.validOut, b0.dataOut}, {1'b1, 16'd8});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/calc_param.md
Name: calc_param

Overview:
- Parametrised token-serial calculator and successor to the 16-bit fixed calculator.
- Accepts a stream of operand and opcode tokens on a valid/ready handshake and runs unary or binary ops at WIDTH bits.
- Multiplies over several cycles with a shift-add datapath and flags overflow and bad opcodes.
- With CHAIN=1 each result becomes the next left operand, so expressions can be accumulated.

Parameters:
- WIDTH, 16: operand/result width in bits; minimum 4.
- CHAIN, 0: 1 = result feeds back as operand A and the FSM waits for an opcode; 0 = return to operand-A state.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear to IDLE; registers zeroed, priority over validIn
- validIn  in  1  dataIn carries a token this cycle
- readyOut  out  1  block can accept a token
- dataIn  in  WIDTH  operand or opcode token
- dataOut  out  WIDTH  echo of accepted operand A, or last result
- validOut  out  1  one-cycle pulse when dataOut holds a new result
- ovf  out  1  overflow/borrow of the last result
- err  out  1  last opcode token was illegal

Behaviour:
- Token accepted at a rising edge where validIn && readyOut.
  - validIn while readyOut=0 is ignored: dropped, no state change.
- Reset (rst_n low, asynchronous): state=IDLE, A=0, op=0, dataOut=0, validOut=0, ovf=0, err=0, readyOut=1.
  - Reset mid-operation aborts immediately; no result or validOut is produced.
- clr: same effect as reset, applied synchronously at the edge.
- validOut is 0 in every cycle except the result cycle.
- States and transitions:
  - IDLE: accept → A=dataIn, dataOut=dataIn, err=0 → OPC. No validOut.
  - OPC: accept → opcode=dataIn.
    - Unary: single-cycle (INC, DEC) → result; SQR → MUL with B=A.
    - Binary → OPB.
    - dataIn > 7 → err=1, dataOut unchanged, → IDLE. A is discarded even when CHAIN=1.
  - OPB: accept → B=dataIn.
    - MUL → MUL state.
    - Other binary ops → result.
  - MUL: readyOut=0. Shift-add, one multiplier bit per cycle, WIDTH cycles total, then → result.
  - Result edge (the same edge that ends the operation):
    - dataOut=result[WIDTH-1:0], ovf updated, validOut=1 for the following cycle.
    - Next state: IDLE if CHAIN=0. If CHAIN=1, OPC with A=result.
- Opcodes:
  - 0 MUL A*B; ovf = any bit of the 2*WIDTH product above WIDTH-1 is set.
  - 1 ADD A+B; ovf = carry out.
  - 2 SQR A*A; ovf as MUL.
  - 3 INC A+1; ovf = carry.
  - 4 SUB A-B; ovf = borrow (A<B).
  - 5 AND A&B; ovf=0.
  - 6 XOR A^B; ovf=0.
  - 7 DEC A-1; ovf = borrow (A=0).
- All arithmetic is unsigned and wraps modulo 2^WIDTH.
- Latency, with token accepted at edge k:
  - ADD/SUB/AND/XOR/INC/DEC: result and validOut visible after edge k.
  - MUL/SQR: readyOut=0 after edge k; result, validOut and readyOut=1 after edge k+WIDTH.
- readyOut=1 in IDLE, OPC and OPB; 0 only in MUL.
- Accepting an operand clears err; ovf holds until the next result.

Test Plan:
- WIDTH=16, CHAIN=0: tokens 12, 1, 30 → dataOut=42, validOut one-cycle pulse, ovf=0, state IDLE.
- MUL: 300, 0, 300 → readyOut low for 16 cycles; dataOut=24464 (90000 mod 65536), ovf=1. A validIn during the busy window is ignored.
- Wrap cases:
  - 0xFFFF, 3 → dataOut=0, ovf=1.
  - 5, 4, 7 → dataOut=0xFFFE, ovf=1.
  - 0, 7 → dataOut=0xFFFF, ovf=1.
- Illegal opcode: 9, 9 → err=1, no validOut, dataOut=9 (operand echo); next token 4 is treated as operand A and err clears.
- CHAIN=1: 3, 2 (SQR → 9), then 1, 1 (ADD 1) → dataOut 9 then 10, two validOut pulses, no operand re-entry.
- rst_n low 8 cycles into a MUL → all outputs zero at once, readyOut=1, no validOut after release. clr in OPB → IDLE at next edge.
